// File: rtl/tmr_scrub_controller.sv
// ---------------------------------------------------------------------------
// tmr_scrub_controller
//
// Periodically sweeps a triplicated (A/B/C) configuration register bank.
// For every word it reads the three copies, forms the bitwise 2-of-3
// majority and, when any copy disagrees, writes the voted value back to all
// three copies. The bank access port is shared with the slow-control master
// through a scrubReq/scrubGnt handshake; the grant may be withdrawn at any
// cycle, in which case the current word is restarted from its read.
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   enable              enables automatic sweeps every PERIOD idle cycles
//   scrubNow            pulse: request one sweep (remembered until served)
//   clrErr              pulse: clear errCount and lastErrAddr
//   scrubReq / scrubGnt bank access port request / grant
//   rdEn, addr          read strobe and address (read data one cycle later)
//   rdA, rdB, rdC       read data of the three copies
//   wrEn, wrData        write strobe and voted data (all three copies)
//   busy                sweep in progress
//   errPulse            one-cycle pulse per corrected word
//   errCount            saturating corrected-word counter
//   lastErrAddr         address of the most recent correction
// ---------------------------------------------------------------------------
module tmr_scrub_controller #(
    parameter int NWORDS = 32,
    parameter int AW     = 5,
    parameter int DW     = 8,
    parameter int PERIOD = 1024,
    parameter int ERRW   = 16
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            enable,
    input  logic            scrubNow,
    input  logic            clrErr,
    output logic            scrubReq,
    input  logic            scrubGnt,
    output logic            rdEn,
    output logic [AW-1:0]   addr,
    input  logic [DW-1:0]   rdA,
    input  logic [DW-1:0]   rdB,
    input  logic [DW-1:0]   rdC,
    output logic            wrEn,
    output logic [DW-1:0]   wrData,
    output logic            busy,
    output logic            errPulse,
    output logic [ERRW-1:0] errCount,
    output logic [AW-1:0]   lastErrAddr
);

    localparam int            TW    = $clog2(PERIOD);
    localparam logic [TW-1:0] TLAST = TW'(PERIOD - 1);
    localparam logic [AW-1:0] PLAST = AW'(NWORDS - 1);

    typedef enum logic [2:0] {
        IDLE, REQ, READ, VOTE, WRITE, NEXT, DONE
    } stateT;

    stateT           state;
    stateT           stateNxt;
    logic [TW-1:0]   timer;
    logic [AW-1:0]   ptr;
    logic            pending;
    logic [DW-1:0]   wrDataReg;
    logic [ERRW-1:0] errCnt;
    logic [AW-1:0]   lastAddr;

    logic            startSweep;
    logic            mismatch;
    logic [DW-1:0]   voted;
    logic            commit;

    function automatic logic [DW-1:0] majority(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input logic [DW-1:0] c);
        return (a & b) | (b & c) | (a & c);
    endfunction

    function automatic logic [ERRW-1:0] satInc(input logic [ERRW-1:0] v);
        return (&v) ? v : v + ERRW'(1);
    endfunction

    // A sweep starts from IDLE on a fresh or remembered scrubNow, or when the
    // enabled idle timer expires.
    assign startSweep = (state == IDLE) &&
                        (pending || scrubNow || (enable && (timer == TLAST)));
    assign voted      = majority(rdA, rdB, rdC);
    assign mismatch   = (rdA != rdB) || (rdB != rdC);
    assign commit     = (state == WRITE) && scrubGnt;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Next-state logic; any grant loss while holding the port restarts the
    // current word from REQ.
    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE:    if (startSweep) stateNxt = REQ;
            REQ:     if (scrubGnt) stateNxt = READ;
            READ:    stateNxt = scrubGnt ? VOTE : REQ;
            VOTE: begin
                if (!scrubGnt)    stateNxt = REQ;
                else if (mismatch) stateNxt = WRITE;
                else              stateNxt = NEXT;
            end
            WRITE:   stateNxt = scrubGnt ? NEXT : REQ;
            NEXT:    stateNxt = (ptr == PLAST) ? DONE : REQ;
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Outputs; strobes are gated by the grant so nothing is issued in a
    // cycle where the port has been taken away.
    always_comb begin
        scrubReq = 1'b0;
        rdEn     = 1'b0;
        wrEn     = 1'b0;
        errPulse = 1'b0;
        addr     = '0;
        busy     = (state != IDLE);
        unique case (state)
            REQ:  scrubReq = 1'b1;
            READ: begin
                scrubReq = scrubGnt;
                rdEn     = scrubGnt;
                addr     = ptr;
            end
            VOTE: scrubReq = scrubGnt;
            WRITE: begin
                scrubReq = scrubGnt;
                wrEn     = scrubGnt;
                errPulse = scrubGnt;
                addr     = ptr;
            end
            NEXT:    scrubReq = 1'b1;
            default: ;
        endcase
    end

    // Timer, pointer, sweep request memory, vote register and status
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer     <= '0;
            ptr       <= '0;
            pending   <= 1'b0;
            wrDataReg <= '0;
            errCnt    <= '0;
            lastAddr  <= '0;
        end else begin
            if (state == IDLE) begin
                if (!enable || startSweep) timer <= '0;
                else                       timer <= timer + TW'(1);
            end

            // In IDLE any remembered request is served at once, so pending
            // only has to survive while a sweep is running.
            pending <= (state == IDLE) ? 1'b0 : (pending | scrubNow);

            if (startSweep) begin
                ptr <= '0;
            end else if ((state == NEXT) && (ptr != PLAST)) begin
                ptr <= ptr + AW'(1);
            end

            if ((state == VOTE) && scrubGnt && mismatch) begin
                wrDataReg <= voted;
            end

            if (clrErr) begin
                errCnt   <= '0;
                lastAddr <= '0;
            end else if (commit) begin
                errCnt   <= satInc(errCnt);
                lastAddr <= ptr;
            end
        end
    end

    assign wrData      = wrDataReg;
    assign errCount    = errCnt;
    assign lastErrAddr = lastAddr;

endmodule

// File: tb/tb_tmr_scrub_controller.sv
module tb_tmr_scrub_controller;

    localparam int NW   = 4;
    localparam int AW   = 2;
    localparam int DW   = 8;
    localparam int PER  = 16;
    localparam int EW   = 3;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rstn, enable, scrubNow, clrErr, scrubGnt;
    logic [DW-1:0] rdA, rdB, rdC;
    logic          scrubReq, rdEn, wrEn, busy, errPulse;
    logic [AW-1:0] addr, lastErrAddr;
    logic [DW-1:0] wrData;
    logic [EW-1:0] errCount;

    always #5 clk = ~clk;

    tmr_scrub_controller #(
        .NWORDS(NW), .AW(AW), .DW(DW), .PERIOD(PER), .ERRW(EW)
    ) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .scrubNow(scrubNow),
        .clrErr(clrErr), .scrubReq(scrubReq), .scrubGnt(scrubGnt),
        .rdEn(rdEn), .addr(addr), .rdA(rdA), .rdB(rdB), .rdC(rdC),
        .wrEn(wrEn), .wrData(wrData), .busy(busy), .errPulse(errPulse),
        .errCount(errCount), .lastErrAddr(lastErrAddr)
    );

    // Bank contents and observation logs
    logic [DW-1:0] memA [NW];
    logic [DW-1:0] memB [NW];
    logic [DW-1:0] memC [NW];

    int            total = 0;
    int            bad   = 0;
    int            mErr, mLast;
    int            nRd, nWr, nPulse, nBusy, nRise;
    int            cyc = 0;
    int            wrAddrQ[$];
    logic [DW-1:0] wrDataQ[$];
    int            riseQ[$];
    int            fallQ[$];
    logic          prevBusy = 1'b0;
    logic          prevRd   = 1'b0;
    logic [AW-1:0] prevAddr = '0;
    bit            dropped;
    int            dropLeft;
    bit            clrPulse = 1'b0;

    typedef struct {
        int            idx;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        int            expWr;
        logic [DW-1:0] expData;
    } vecT;

    vecT vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-bit vote by counting ones
    function automatic logic [DW-1:0] majBits(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic [DW-1:0] c);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) begin
            int n;
            n = int'(a[i]) + int'(b[i]) + int'(c[i]);
            r[i] = (n >= 2);
        end
        return r;
    endfunction

    task automatic cleanBank();
        for (int i = 0; i < NW; i++) begin
            memA[i] = DW'(i * 37 + 3);
            memB[i] = memA[i];
            memC[i] = memA[i];
        end
    endtask

    task automatic badWord(input int i);
        memC[i] = ~memA[i];
    endtask

    task automatic randomBank();
        for (int i = 0; i < NW; i++) begin
            logic [DW-1:0] base;
            int            r;
            base    = DW'($urandom_range(0, 255));
            memA[i] = base;
            memB[i] = base;
            memC[i] = base;
            r = $urandom_range(0, 9);
            if (r < 4) begin
                case ($urandom_range(0, 2))
                    0:       memA[i] = base ^ DW'($urandom_range(1, 255));
                    1:       memB[i] = base ^ DW'($urandom_range(1, 255));
                    default: memC[i] = base ^ DW'($urandom_range(1, 255));
                endcase
            end else if (r == 4) begin
                memA[i] = DW'($urandom_range(0, 255));
                memB[i] = DW'($urandom_range(0, 255));
                memC[i] = DW'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic clearLog();
        nRd = 0; nWr = 0; nPulse = 0; nBusy = 0; nRise = 0;
        wrAddrQ.delete(); wrDataQ.delete();
        riseQ.delete(); fallQ.delete();
        dropped = 0; dropLeft = 0;
    endtask

    // One clock cycle, entered 1 time unit after a rising edge.
    // pol: 0 grant held, 1 random grant, 2 grant dropped in VOTE of word 1.
    task automatic step(input int pol);
        logic          curRd;
        logic [AW-1:0] curAddr;
        case (pol)
            0: scrubGnt = 1'b1;
            1: scrubGnt = ($urandom_range(0, 3) != 0);
            default: begin
                if (dropLeft > 0) begin
                    scrubGnt = 1'b0;
                    dropLeft--;
                end else if (!dropped && prevRd && (prevAddr == AW'(1))) begin
                    scrubGnt = 1'b0;
                    dropped  = 1;
                    dropLeft = 2;
                end else begin
                    scrubGnt = 1'b1;
                end
            end
        endcase
        #1;
        if (rdEn) nRd++;
        if (wrEn) begin
            nWr++;
            wrAddrQ.push_back(int'(addr));
            wrDataQ.push_back(wrData);
        end
        if (errPulse) nPulse++;
        if (busy) nBusy++;
        if (busy && !prevBusy) begin nRise++; riseQ.push_back(cyc); end
        if (!busy && prevBusy) fallQ.push_back(cyc);
        prevBusy = busy;
        if (clrPulse && errPulse) clrErr = 1'b1;
        curRd   = rdEn;
        curAddr = addr;
        cyc++;
        @(posedge clk);
        #1;
        clrErr   = 1'b0;
        scrubNow = 1'b0;
        if (curRd) begin
            rdA = memA[curAddr];
            rdB = memB[curAddr];
            rdC = memC[curAddr];
        end
        prevRd   = curRd;
        prevAddr = curAddr;
    endtask

    task automatic steps(input int n, input int pol);
        for (int i = 0; i < n; i++) step(pol);
    endtask

    task automatic runUntil(input int pol, input int nSweeps, input int bound);
        int n;
        n = 0;
        while (!((nRise >= nSweeps) && !prevBusy) && (n < bound)) begin
            step(pol);
            n++;
        end
        chk("sweepFinished", int'((nRise >= nSweeps) && !prevBusy), 1);
    endtask

    task automatic sweep(input int pol);
        clearLog();
        scrubNow = 1'b1;
        runUntil(pol, 1, 3000);
    endtask

    // Reference: every disagreeing word is written once, in address order,
    // with its per-bit majority; status follows the corrections.
    task automatic checkSweep(input string tag);
        int            ea[$];
        logic [DW-1:0] ed[$];
        int            n;
        for (int i = 0; i < NW; i++) begin
            if (!((memA[i] == memB[i]) && (memB[i] == memC[i]))) begin
                ea.push_back(i);
                ed.push_back(majBits(memA[i], memB[i], memC[i]));
            end
        end
        chk({tag, ".writes"}, wrAddrQ.size(), ea.size());
        n = (wrAddrQ.size() < ea.size()) ? wrAddrQ.size() : ea.size();
        for (int k = 0; k < n; k++) begin
            chk({tag, ".wrAddr"}, wrAddrQ[k], ea[k]);
            chk({tag, ".wrData"}, int'(wrDataQ[k]), int'(ed[k]));
        end
        chk({tag, ".errPulses"}, nPulse, ea.size());
        mErr = (mErr + ea.size() > EMAX) ? EMAX : mErr + ea.size();
        if (ea.size() > 0) mLast = ea[ea.size() - 1];
        chk({tag, ".errCount"}, int'(errCount), mErr);
        chk({tag, ".lastErrAddr"}, int'(lastErrAddr), mLast);
    endtask

    initial begin
        int e, e2;

        vecs[0] = '{2, 8'h5A, 8'h5A, 8'hFF, 1, 8'h5A};
        vecs[1] = '{1, 8'h0F, 8'h3C, 8'hF0, 1, 8'h3C};
        vecs[2] = '{0, 8'hA5, 8'hA5, 8'hA5, 0, 8'h00};
        vecs[3] = '{3, 8'h00, 8'hFF, 8'h00, 1, 8'h00};
        vecs[4] = '{3, 8'h81, 8'h81, 8'h7E, 1, 8'h81};
        vecs[5] = '{0, 8'h12, 8'h34, 8'h34, 1, 8'h34};

        rstn = 1'b0; enable = 1'b0; scrubNow = 1'b0; clrErr = 1'b0;
        scrubGnt = 1'b1; rdA = '0; rdB = '0; rdC = '0;
        mErr = 0; mLast = 0;
        cleanBank();
        clearLog();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", int'(busy), 0);
        chk("rst.scrubReq", int'(scrubReq), 0);
        chk("rst.rdEn", int'(rdEn), 0);
        chk("rst.wrEn", int'(wrEn), 0);
        chk("rst.errPulse", int'(errPulse), 0);
        chk("rst.errCount", int'(errCount), 0);
        chk("rst.lastErrAddr", int'(lastErrAddr), 0);
        chk("rst.wrData", int'(wrData), 0);
        rstn = 1'b1;

        // Clean bank
        cleanBank();
        sweep(0);
        chk("clean.reads", nRd, NW);
        chk("clean.busyCycles", nBusy, 17);
        checkSweep("clean");

        // Vote vectors, one bad word per sweep
        for (int v = 0; v < 6; v++) begin
            cleanBank();
            memA[vecs[v].idx] = vecs[v].a;
            memB[vecs[v].idx] = vecs[v].b;
            memC[vecs[v].idx] = vecs[v].c;
            sweep(0);
            chk("vec.writes", nWr, vecs[v].expWr);
            if (wrAddrQ.size() > 0) begin
                chk("vec.wrAddr", wrAddrQ[0], vecs[v].idx);
                chk("vec.wrData", int'(wrDataQ[0]), int'(vecs[v].expData));
            end
            chk("vec.busyCycles", nBusy, 4 * NW + 1 + vecs[v].expWr);
            checkSweep("vec");
        end

        // Grant withdrawn in the VOTE cycle of word 1
        cleanBank();
        badWord(1);
        sweep(2);
        chk("drop.reads", nRd, NW + 1);
        checkSweep("drop");

        // scrubNow during a sweep queues exactly one more sweep
        cleanBank();
        clearLog();
        scrubNow = 1'b1;
        step(0);
        steps(8, 0);
        scrubNow = 1'b1;
        runUntil(0, 2, 500);
        steps(20, 0);
        chk("again.sweeps", nRise, 2);
        chk("again.reads", nRd, 2 * NW);
        chk("again.busyCycles", nBusy, 34);
        checkSweep("again");

        // Random banks under a random grant
        for (int r = 0; r < 10; r++) begin
            randomBank();
            sweep(1);
            checkSweep("rand");
        end

        // Saturation
        for (int r = 0; r < 3; r++) begin
            cleanBank();
            for (int i = 0; i < NW; i++) badWord(i);
            sweep(0);
            checkSweep("sat");
        end
        chk("sat.allOnes", int'(errCount), EMAX);

        // clrErr in the same cycle as errPulse
        cleanBank();
        badWord(2);
        clrPulse = 1'b1;
        sweep(0);
        clrPulse = 1'b0;
        chk("clr.pulses", nPulse, 1);
        chk("clr.errCount", int'(errCount), 0);
        mErr = 0; mLast = 0;
        cleanBank();
        badWord(3);
        sweep(0);
        checkSweep("afterClr");

        // Automatic sweeps from the idle timer
        cleanBank();
        clearLog();
        enable = 1'b1;
        e = cyc;
        steps(60, 0);
        enable = 1'b0;           // drops while the second sweep runs
        steps(60, 0);
        chk("timer.first", (riseQ.size() > 0) ? riseQ[0] - e : -1, PER);
        chk("timer.len", (fallQ.size() > 0 && riseQ.size() > 0) ? fallQ[0] - riseQ[0] : -1, 17);
        chk("timer.gap", (riseQ.size() > 1 && fallQ.size() > 0) ? riseQ[1] - fallQ[0] : -1, PER);
        chk("timer.sweeps", riseQ.size(), 2);
        chk("timer.finishAfterDisable", (fallQ.size() > 1) ? fallQ[1] - riseQ[1] : -1, 17);
        chk("timer.reads", nRd, 2 * NW);
        enable = 1'b1;
        steps(5, 0);
        enable = 1'b0;
        steps(10, 0);
        enable = 1'b1;
        e2 = cyc;
        steps(30, 0);
        enable = 1'b0;
        steps(40, 0);
        chk("timer.restart", (riseQ.size() > 2) ? riseQ[2] - e2 : -1, PER);
        chk("timer.sweepsTotal", riseQ.size(), 3);

        // Reset while a correction is about to be written
        cleanBank();
        for (int i = 0; i < NW; i++) badWord(i);
        clearLog();
        scrubNow = 1'b1;
        steps(4, 0);
        rstn = 1'b0;
        #1;
        chk("midRst.wrEn", int'(wrEn), 0);
        chk("midRst.busy", int'(busy), 0);
        chk("midRst.scrubReq", int'(scrubReq), 0);
        chk("midRst.errCount", int'(errCount), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mErr = 0; mLast = 0;
        prevBusy = 1'b0; prevRd = 1'b0;
        clearLog();
        steps(40, 0);
        chk("midRst.noWrite", nWr, 0);
        chk("midRst.noSweep", nRise, 0);
        cleanBank();
        badWord(1);
        sweep(0);
        checkSweep("postRst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
